// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states, strobe constants
// and the alignment rule.
package mau_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_RD,
      S_WB
   } state_e;

   localparam logic [3:0] WSTRB_ALL = 4'b1111;

   // Reserved size is reported as misaligned so it never reaches memory.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lane[0];
         SZ_WORD: return lane != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mau_if.sv
// Core request, memory request/response and register-file write bundle of the memory access
// unit. The master side is the environment (core + memory); the slave side is the unit.
interface mau_if #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned RF_ADDR_WIDTH = 5
);
   logic                     req_valid;
   logic                     req_ready;
   logic                     req_wr;
   logic [1:0]               req_size;
   logic                     req_signed;
   logic [ADDR_WIDTH-1:0]    req_addr;
   logic [DATA_WIDTH-1:0]    req_wdata;
   logic [RF_ADDR_WIDTH-1:0] req_rd;
   logic                     mem_req_valid;
   logic                     mem_req_ready;
   logic                     mem_wen;
   logic [ADDR_WIDTH-1:0]    mem_addr;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic [3:0]               mem_wstrb;
   logic                     mem_rdata_valid;
   logic                     mem_rdata_ready;
   logic [DATA_WIDTH-1:0]    mem_rdata;
   logic                     rf_wen;
   logic [RF_ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0]    rf_wdata;
   logic                     done;
   logic                     err_misalign;

   modport master (
      output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, req_rd,
             mem_req_ready, mem_rdata_valid, mem_rdata,
      input  req_ready, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
             mem_rdata_ready, rf_wen, rf_waddr, rf_wdata, done, err_misalign
   );

   modport slave (
      input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, req_rd,
             mem_req_ready, mem_rdata_valid, mem_rdata,
      output req_ready, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
             mem_rdata_ready, rf_wen, rf_waddr, rf_wdata, done, err_misalign
   );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word lane of a read word and sign- or zero-extends it.
module load_extend
   import mau_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            lane,
   input  logic [1:0]            size,
   input  logic                  is_signed,
   output logic [DATA_WIDTH-1:0] data
);
   logic [4:0]  bit_off;
   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   always_comb begin
      bit_off = {lane, 3'b000};
      sel_b   = rdata[bit_off +: 8];
      sel_h   = rdata[bit_off +: 16];
      case (size)
         SZ_BYTE: data = {{(DATA_WIDTH - 8){is_signed & sel_b[7]}}, sel_b};
         SZ_HALF: data = {{(DATA_WIDTH - 16){is_signed & sel_h[15]}}, sel_h};
         default: data = rdata;
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator: aligns core accesses onto the word bus, runs the
// memory request/response handshakes and writes extended load data to the register file.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned RF_ADDR_WIDTH = 5
) (
   input logic  clk,
   input logic  rst_n,
   mau_if.slave bus
);
   state_e                   state_q, state_d;
   logic                     wr_q, signed_q, err_q;
   logic [1:0]               size_q;
   logic [ADDR_WIDTH-1:0]    addr_q;
   logic [DATA_WIDTH-1:0]    wdata_q, rdata_q, load_data;
   logic [RF_ADDR_WIDTH-1:0] rd_q;
   logic [1:0]               lane;
   logic                     accept, req_mis;

   assign lane    = addr_q[1:0];
   assign accept  = (state_q == S_IDLE) && bus.req_valid;
   assign req_mis = is_misaligned(bus.req_size, bus.req_addr[1:0]);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.req_valid) state_d = req_mis ? S_WB : S_REQ;
         S_REQ:     if (bus.mem_req_ready) state_d = wr_q ? S_WB : S_WAIT_RD;
         S_WAIT_RD: if (bus.mem_rdata_valid) state_d = S_WB;
         S_WB:      state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_q     <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= '0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            wr_q     <= bus.req_wr;
            signed_q <= bus.req_signed;
            err_q    <= req_mis;
            size_q   <= bus.req_size;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rd_q     <= bus.req_rd;
         end
         if ((state_q == S_WAIT_RD) && bus.mem_rdata_valid) rdata_q <= bus.mem_rdata;
      end
   end

   load_extend #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_load_extend (
      .rdata    (rdata_q),
      .lane     (lane),
      .size     (size_q),
      .is_signed(signed_q),
      .data     (load_data)
   );

   // Every output below depends only on registered state.
   always_comb begin
      bus.req_ready       = (state_q == S_IDLE);
      bus.mem_req_valid   = (state_q == S_REQ);
      bus.mem_rdata_ready = (state_q == S_WAIT_RD);
      bus.mem_wen         = wr_q;
      bus.mem_addr        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      bus.mem_wdata       = wdata_q;
      bus.mem_wstrb       = 4'b0000;
      if (wr_q) begin
         case (size_q)
            SZ_BYTE: begin
               bus.mem_wdata = {(DATA_WIDTH / 8){wdata_q[7:0]}};
               bus.mem_wstrb = 4'b0001 << lane;
            end
            SZ_HALF: begin
               bus.mem_wdata = {(DATA_WIDTH / 16){wdata_q[15:0]}};
               bus.mem_wstrb = 4'b0011 << lane;
            end
            default: bus.mem_wstrb = WSTRB_ALL;
         endcase
      end
      bus.done         = (state_q == S_WB);
      bus.err_misalign = (state_q == S_WB) && err_q;
      bus.rf_wen       = (state_q == S_WB) && !wr_q && !err_q && (rd_q != '0);
      bus.rf_waddr     = rd_q;
      bus.rf_wdata     = load_data;
   end
endmodule
